// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-to-host receiver: FSM states,
// frame constants and the odd-parity rule.
package ps2_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int   DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Data bits plus parity bit must carry an odd number of ones.
    function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
        return (^{d, p}) == 1'b1;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length deglitch filter for a raw PS/2 line;
// emits a registered single-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 4
) (
    input  logic clk50,
    input  logic rst,
    input  logic line,
    output logic fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic          fclk;
    logic          fclk_d;
    logic [CW-1:0] run;

    always_ff @(posedge clk50) begin
        if (rst) begin
            sync   <= 2'b11;
            fclk   <= 1'b1;
            fclk_d <= 1'b1;
            run    <= '0;
            fall   <= 1'b0;
        end else begin
            sync   <= {sync[0], line};
            fclk_d <= fclk;
            fall   <= fclk_d & ~fclk;
            // Any sample matching the current level restarts the run.
            if (sync[1] == fclk) begin
                run <= '0;
            end else if (run == CW'(FILTER_LEN - 1)) begin
                fclk <= sync[1];
                run  <= '0;
            end else begin
                run <= run + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, checks start/parity/stop,
// strobes good bytes to port_controller and flags rejected or stalled frames.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk50,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    output logic [DATA_BITS-1:0] ps2_data,
    output logic                 ps2_data_clk,
    output logic                 ps2_err,
    output logic                 busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BW = $clog2(DATA_BITS);

    logic                 fall;
    logic [1:0]           dat_sync;
    logic                 dat;
    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bitcnt;
    logic                 par;
    logic                 ok_pend;
    logic                 err_pend;
    logic [TW-1:0]        tcnt;

    assign dat = dat_sync[1];

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk50 (clk50),
        .rst   (rst),
        .line  (ps2_clk),
        .fall  (fall)
    );

    always_ff @(posedge clk50) begin
        if (rst) begin
            dat_sync     <= 2'b11;
            state        <= IDLE;
            shreg        <= '0;
            bitcnt       <= '0;
            par          <= 1'b0;
            ok_pend      <= 1'b0;
            err_pend     <= 1'b0;
            tcnt         <= '0;
            ps2_data     <= '0;
            ps2_data_clk <= 1'b0;
            ps2_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            dat_sync     <= {dat_sync[0], ps2_dat};
            ok_pend      <= 1'b0;
            err_pend     <= 1'b0;
            ps2_data_clk <= ok_pend;
            ps2_err      <= err_pend;
            if (ok_pend)
                ps2_data <= shreg;

            // A fall always takes priority over an expiring timeout.
            if (fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (dat == START_BIT) begin
                            state  <= DATA;
                            bitcnt <= '0;
                            busy   <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg  <= {dat, shreg[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == BW'(DATA_BITS - 1))
                            state <= PARITY;
                    end
                    PARITY: begin
                        par   <= dat;
                        state <= STOP;
                    end
                    STOP: begin
                        if (dat == STOP_BIT && parity_ok(shreg, par))
                            ok_pend <= 1'b1;
                        else
                            err_pend <= 1'b1;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state   <= IDLE;
                busy    <= 1'b0;
                ps2_err <= 1'b1;
                tcnt    <= '0;
            end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: table of whole frames plus hand-written
// timeout, glitch and mid-frame reset sequences.
module tb_ps2_receiver;

    localparam int FILTER_LEN = 4;
    localparam int TIMEOUT    = 200;
    localparam int LAT        = FILTER_LEN + 4;

    logic       clk50 = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] ps2_data;
    logic       ps2_data_clk;
    logic       ps2_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_stb = 0, n_err = 0, both_seen = 0;
    int stb_cyc = 0, err_cyc = 0;
    int fall_edge = 0;

    ps2_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk50        (clk50),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .ps2_data     (ps2_data),
        .ps2_data_clk (ps2_data_clk),
        .ps2_err      (ps2_err),
        .busy         (busy)
    );

    always #5 clk50 = ~clk50;

    always @(posedge clk50) cyc <= cyc + 1;

    always @(negedge clk50) begin
        if (ps2_data_clk) begin
            n_stb   <= n_stb + 1;
            stb_cyc <= cyc;
        end
        if (ps2_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        if (ps2_data_clk && ps2_err)
            both_seen <= both_seen + 1;
    end

    typedef struct {
        logic [7:0] d;
        bit         flip_par;
        bit         stop;
        bit         exp_ok;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic glitch(input int n);
        ps2_clk = 1'b0;
        repeat (n) @(negedge clk50);
        ps2_clk = 1'b1;
        repeat (6) @(negedge clk50);
    endtask

    // Sends the first nbits of a frame; glitches are injected in the high
    // phase preceding bit index glitch_bit.
    task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit stopb,
                              input int nbits, input int glitch_bit);
        logic [10:0] f;
        f = {stopb, (~^d) ^ flip_par, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            repeat (20) @(negedge clk50);
            if (i == glitch_bit) begin
                glitch(2);
                glitch(3);
            end
            ps2_dat = f[i];
            repeat (20) @(negedge clk50);
            ps2_clk   = 1'b0;
            fall_edge = cyc + 1;
            repeat (40) @(negedge clk50);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic good_frame(input string name, input logic [7:0] d, input int glitch_bit);
        int bs, be;
        bs = n_stb;
        be = n_err;
        send_frame(d, 1'b0, 1'b1, 11, glitch_bit);
        repeat (10) @(negedge clk50);
        check({name, "_data"}, ps2_data, d);
        check({name, "_strobes"}, n_stb - bs, 1);
        check({name, "_errs"}, n_err - be, 0);
        check({name, "_lat"}, stb_cyc - fall_edge, LAT);
    endtask

    initial begin
        int bs, be;
        vecs[0] = '{8'h76, 1'b0, 1'b1, 1'b1, 8'h76};
        vecs[1] = '{8'h2E, 1'b0, 1'b1, 1'b1, 8'h2E};
        vecs[2] = '{8'hF0, 1'b0, 1'b1, 1'b1, 8'hF0};
        vecs[3] = '{8'h76, 1'b1, 1'b1, 1'b0, 8'hF0};
        vecs[4] = '{8'h76, 1'b0, 1'b0, 1'b0, 8'hF0};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF};

        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (3) @(negedge clk50);
        check("rst_data", ps2_data, 8'h00);
        check("rst_data_clk", ps2_data_clk, 1'b0);
        check("rst_err", ps2_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk50);

        foreach (vecs[k]) begin
            bs = n_stb;
            be = n_err;
            send_frame(vecs[k].d, vecs[k].flip_par, vecs[k].stop, 11, -1);
            repeat (10) @(negedge clk50);
            check($sformatf("vec%0d_data", k), ps2_data, vecs[k].exp_data);
            check($sformatf("vec%0d_strobes", k), n_stb - bs, vecs[k].exp_ok ? 1 : 0);
            check($sformatf("vec%0d_errs", k), n_err - be, vecs[k].exp_ok ? 0 : 1);
            check($sformatf("vec%0d_busy", k), busy, 1'b0);
            if (vecs[k].exp_ok)
                check($sformatf("vec%0d_lat", k), stb_cyc - fall_edge, LAT);
            else
                check($sformatf("vec%0d_err_lat", k), err_cyc - fall_edge, LAT);
        end

        // Stalled frame: start plus five data bits, then lines idle high.
        bs = n_stb;
        be = n_err;
        send_frame(8'h76, 1'b0, 1'b1, 6, -1);
        check("tmo_busy_mid", busy, 1'b1);
        for (int i = 0; i < 400 && n_err == be; i++) @(negedge clk50);
        repeat (2) @(negedge clk50);
        check("tmo_errs", n_err - be, 1);
        check("tmo_when", err_cyc - fall_edge, FILTER_LEN + 3 + TIMEOUT);
        check("tmo_busy", busy, 1'b0);
        check("tmo_strobes", n_stb - bs, 0);
        check("tmo_data_kept", ps2_data, 8'hFF);
        good_frame("after_tmo", 8'h76, -1);

        // Short clock glitches in idle with data low, then mid-frame.
        bs = n_stb;
        be = n_err;
        ps2_dat = 1'b0;
        repeat (10) @(negedge clk50);
        glitch(2);
        glitch(3);
        repeat (10) @(negedge clk50);
        check("glitch_idle_busy", busy, 1'b0);
        ps2_dat = 1'b1;
        repeat (20) @(negedge clk50);
        check("glitch_idle_events", (n_stb - bs) + (n_err - be), 0);
        good_frame("glitch_mid", 8'h2E, 4);

        // Reset after four data bits abandons the frame silently.
        send_frame(8'hAA, 1'b0, 1'b1, 5, -1);
        bs = n_stb;
        be = n_err;
        repeat (10) @(negedge clk50);
        rst = 1'b1;
        @(negedge clk50);
        rst = 1'b0;
        check("mrst_data", ps2_data, 8'h00);
        check("mrst_busy", busy, 1'b0);
        check("mrst_data_clk", ps2_data_clk, 1'b0);
        check("mrst_err", ps2_err, 1'b0);
        repeat (TIMEOUT + 100) @(negedge clk50);
        check("mrst_no_events", (n_stb - bs) + (n_err - be), 0);
        good_frame("after_rst", 8'h76, -1);

        check("strobes_exclusive", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
